// File: rtl/packet_framebuffer_writer.sv
// Packet consumer: pixel strobes become frame-buffer writes,
// audio strobes feed a sample FIFO drained by audio_tick.
module packet_framebuffer_writer #(
  parameter int PIXELS_PER_PACKET = 320,
  parameter int FB_DEPTH          = 76800,
  parameter int AUDIO_DEPTH       = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_valid,
  input  logic        addr_axiiv,
  input  logic [23:0] addr,
  input  logic        pixel_axiiv,
  input  logic [7:0]  pixel,
  input  logic        audio_axiiv,
  input  logic [7:0]  audio,
  input  logic        audio_tick,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic [7:0]  audio_out,
  output logic        audio_out_valid,
  output logic        audio_underflow,
  output logic        audio_overflow,
  output logic        pkt_done,
  output logic        pkt_error,
  output logic [15:0] pkt_count
);

  localparam int IW = $clog2(PIXELS_PER_PACKET);
  localparam int AW = $clog2(AUDIO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(PIXELS_PER_PACKET - 1);
  localparam logic [24:0]   PPP      = 25'(PIXELS_PER_PACKET);
  localparam logic [24:0]   FBD      = 25'(FB_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(AUDIO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PIXELS,
    AUDIO,
    DROP
  } state_t;

  state_t state, state_n;

  logic          pkt_valid_d;
  logic          eop;
  logic          addr_oor;
  logic [16:0]   base, base_n;
  logic [IW-1:0] idx, idx_n;
  logic          fb_we_n;
  logic [16:0]   fb_addr_n;
  logic [7:0]    fb_data_n;
  logic          done_n;
  logic          err_n;
  logic          push_req;

  logic [7:0]    mem [AUDIO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign eop      = pkt_valid_d & ~pkt_valid;
  assign addr_oor = ({1'b0, addr} + PPP) > FBD;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = audio_tick & ~empty;
  assign push  = push_req & (~full | pop);

  // Packet state and per-packet write position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pkt_valid_d <= 1'b0;
      base        <= '0;
      idx         <= '0;
    end else begin
      state       <= state_n;
      pkt_valid_d <= pkt_valid;
      base        <= base_n;
      idx         <= idx_n;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_n   = state;
    base_n    = base;
    idx_n     = idx;
    fb_we_n   = 1'b0;
    fb_addr_n = fb_addr;
    fb_data_n = fb_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    push_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (addr_axiiv) begin
          if (addr_oor) begin
            err_n   = 1'b1;
            state_n = DROP;
          end else begin
            base_n  = addr[16:0];
            idx_n   = '0;
            state_n = PIXELS;
          end
        end
      end
      PIXELS: begin
        if (pixel_axiiv) begin
          fb_we_n   = 1'b1;
          fb_addr_n = base + 17'(idx);
          fb_data_n = pixel;
          idx_n     = idx + 1'b1;
        end
        if (pixel_axiiv && idx == LAST_IDX) begin
          if (eop) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = AUDIO;
          end
        end else if (eop) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      AUDIO: begin
        push_req = audio_axiiv;
        if (eop) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      DROP: begin
        if (eop) state_n = IDLE;
      end
    endcase
  end

  // Frame-buffer port and packet status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      pkt_done  <= 1'b0;
      pkt_error <= 1'b0;
      pkt_count <= '0;
    end else begin
      fb_we     <= fb_we_n;
      fb_addr   <= fb_addr_n;
      fb_data   <= fb_data_n;
      pkt_done  <= done_n;
      pkt_error <= err_n;
      pkt_count <= pkt_count + 16'(done_n);
    end
  end

  // Audio sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= audio;
  end

  // FIFO pointers, occupancy and sample-rate output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
      audio_underflow <= 1'b0;
      audio_overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        audio_out <= mem[rd_ptr];
      end
      unique case (1'b1)
        push & ~pop: count <= count + 1'b1;
        pop & ~push: count <= count - 1'b1;
        default: ;
      endcase
      audio_out_valid <= pop;
      audio_underflow <= audio_tick & empty;
      audio_overflow  <= push_req & full & ~pop;
    end
  end

endmodule

// File: tb/tb_packet_framebuffer_writer.sv
// Bench for packet_framebuffer_writer: packet table plus
// scoreboarded frame-buffer writes and audio samples.
module tb_packet_framebuffer_writer;

  logic        clk;
  logic        rst_n;
  logic        pkt_valid;
  logic        addr_axiiv;
  logic [23:0] addr;
  logic        pixel_axiiv;
  logic [7:0]  pixel;
  logic        audio_axiiv;
  logic [7:0]  audio;
  logic        audio_tick;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic [7:0]  audio_out;
  logic        audio_out_valid;
  logic        audio_underflow;
  logic        audio_overflow;
  logic        pkt_done;
  logic        pkt_error;
  logic [15:0] pkt_count;

  packet_framebuffer_writer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pkt_valid       (pkt_valid),
    .addr_axiiv      (addr_axiiv),
    .addr            (addr),
    .pixel_axiiv     (pixel_axiiv),
    .pixel           (pixel),
    .audio_axiiv     (audio_axiiv),
    .audio           (audio),
    .audio_tick      (audio_tick),
    .fb_we           (fb_we),
    .fb_addr         (fb_addr),
    .fb_data         (fb_data),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .audio_underflow (audio_underflow),
    .audio_overflow  (audio_overflow),
    .pkt_done        (pkt_done),
    .pkt_error       (pkt_error),
    .pkt_count       (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    int          npix;
    int          naud;
    bit          tick;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tab [5];

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_fb [$];
  logic [7:0]  exp_au [$];
  logic [7:0]  mq     [$];

  int done_seen = 0;
  int err_seen  = 0;
  int ovf_seen  = 0;
  int udf_seen  = 0;
  int exp_ovf   = 0;
  int exp_udf   = 0;
  int exp_cnt   = 0;
  logic [16:0] last_addr;
  logic [7:0]  aud_seq = 8'h11;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare DUT output events with queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) begin
        if (exp_fb.size() == 0) chk("fb_we_unexpected", 32'(fb_we), 0);
        else chk("fb_write", {fb_addr, fb_data}, exp_fb.pop_front());
        last_addr = fb_addr;
      end
      if (audio_out_valid) begin
        if (exp_au.size() == 0) chk("au_unexpected", 32'(audio_out_valid), 0);
        else chk("audio_out", audio_out, exp_au.pop_front());
      end
      if (pkt_done)        done_seen++;
      if (pkt_error)       err_seen++;
      if (audio_overflow)  ovf_seen++;
      if (audio_underflow) udf_seen++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_tick();
    if (mq.size() > 0) exp_au.push_back(mq.pop_front());
    else exp_udf++;
  endtask

  task automatic send_pkt(input logic [23:0] a, input int npix,
                          input int naud, input bit tk);
    bit acc;
    bit full;
    acc  = (int'(a) + 320 <= 76800);
    full = acc && (npix >= 320);
    cyc();
    pkt_valid  = 1'b1;
    addr_axiiv = 1'b1;
    addr       = a;
    for (int i = 0; i < npix; i++) begin
      cyc();
      addr_axiiv  = 1'b0;
      pixel_axiiv = 1'b1;
      pixel       = 8'(i);
      if (acc) exp_fb.push_back({17'(int'(a) + i), 8'(i)});
    end
    for (int j = 0; j < naud; j++) begin
      cyc();
      addr_axiiv  = 1'b0;
      pixel_axiiv = 1'b0;
      audio_axiiv = 1'b1;
      audio       = aud_seq;
      audio_tick  = tk;
      if (tk) model_tick();
      if (full) begin
        if (mq.size() < 256) mq.push_back(aud_seq);
        else exp_ovf++;
      end
      aud_seq = aud_seq + 8'd7;
    end
    cyc();
    addr_axiiv  = 1'b0;
    pixel_axiiv = 1'b0;
    audio_axiiv = 1'b0;
    audio_tick  = 1'b0;
    pkt_valid   = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_tick();
    cyc();
    audio_tick = 1'b1;
    model_tick();
    cyc();
    audio_tick = 1'b0;
  endtask

  task automatic drain();
    int n;
    int u0;
    logic [7:0] held;
    n = mq.size();
    repeat (n) do_tick();
    repeat (2) cyc();
    held = audio_out;
    u0   = udf_seen;
    do_tick();
    repeat (2) cyc();
    chk("underflow_pulse", 32'(udf_seen - u0), 1);
    chk("underflow_hold", audio_out, held);
    chk("audio_drained", 32'(exp_au.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, e0, o0;

    tab[0] = '{24'h000140, 320, 4, 1'b0, 1, 0};
    tab[1] = '{24'd76481,  320, 2, 1'b0, 0, 1};
    tab[2] = '{24'd76480,  320, 0, 1'b0, 1, 0};
    tab[3] = '{24'd0,      100, 0, 1'b0, 0, 1};
    tab[4] = '{24'd0,      320, 2, 1'b0, 1, 0};

    rst_n       = 1'b0;
    pkt_valid   = 1'b0;
    addr_axiiv  = 1'b0;
    addr        = '0;
    pixel_axiiv = 1'b0;
    pixel       = '0;
    audio_axiiv = 1'b0;
    audio       = '0;
    audio_tick  = 1'b0;
    repeat (3) cyc();
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_data", 32'(fb_data), 0);
    chk("rst_audio_out", 32'(audio_out), 0);
    chk("rst_au_valid", 32'(audio_out_valid), 0);
    chk("rst_underflow", 32'(audio_underflow), 0);
    chk("rst_overflow", 32'(audio_overflow), 0);
    chk("rst_done", 32'(pkt_done), 0);
    chk("rst_error", 32'(pkt_error), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    for (int k = 0; k < 5; k++) begin
      d0 = done_seen;
      e0 = err_seen;
      send_pkt(tab[k].addr, tab[k].npix, tab[k].naud, tab[k].tick);
      exp_cnt += tab[k].exp_done;
      chk($sformatf("pkt%0d_done", k), 32'(done_seen - d0),
          32'(tab[k].exp_done));
      chk($sformatf("pkt%0d_err", k), 32'(err_seen - e0),
          32'(tab[k].exp_err));
      chk($sformatf("pkt%0d_fb_left", k), 32'(exp_fb.size()), 0);
      chk($sformatf("pkt%0d_count", k), 32'(pkt_count), 32'(exp_cnt));
      chk($sformatf("pkt%0d_ovf", k), 32'(ovf_seen), 32'(exp_ovf));
      if (k == 2) chk("last_fb_addr", 32'(last_addr), 32'd76799);
    end

    drain();

    o0 = ovf_seen;
    send_pkt(24'd0, 320, 300, 1'b0);
    exp_cnt++;
    chk("full_ovf_count", 32'(ovf_seen - o0), 44);
    chk("full_ovf_model", 32'(ovf_seen), 32'(exp_ovf));
    chk("full_stored", 32'(mq.size()), 256);

    o0 = ovf_seen;
    send_pkt(24'd0, 320, 1, 1'b1);
    exp_cnt++;
    repeat (2) cyc();
    chk("full_pushpop_ovf", 32'(ovf_seen - o0), 0);
    chk("full_pushpop_head", 32'(exp_au.size()), 0);
    chk("pkt_count_full", 32'(pkt_count), 32'(exp_cnt));
    drain();
    chk("udf_model", 32'(udf_seen), 32'(exp_udf));

    send_pkt(24'd0, 320, 3, 1'b0);
    exp_cnt++;

    cyc();
    pkt_valid  = 1'b1;
    addr_axiiv = 1'b1;
    addr       = 24'h000100;
    for (int i = 0; i < 50; i++) begin
      cyc();
      addr_axiiv  = 1'b0;
      pixel_axiiv = 1'b1;
      pixel       = 8'(i);
      exp_fb.push_back({17'(256 + i), 8'(i)});
    end
    cyc();
    pixel_axiiv = 1'b0;
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    pkt_valid = 1'b0;
    #1;
    chk("arst_fb_we", 32'(fb_we), 0);
    chk("arst_fb_addr", 32'(fb_addr), 0);
    chk("arst_pkt_count", 32'(pkt_count), 0);
    chk("arst_fb_left", 32'(exp_fb.size()), 0);
    mq.delete();
    exp_au.delete();
    exp_cnt = 0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    d0 = udf_seen;
    do_tick();
    repeat (2) cyc();
    chk("arst_fifo_empty", 32'(udf_seen - d0), 1);

    d0 = done_seen;
    send_pkt(24'h000100, 320, 0, 1'b0);
    exp_cnt++;
    chk("post_rst_done", 32'(done_seen - d0), 1);
    chk("post_rst_fb_left", 32'(exp_fb.size()), 0);
    chk("post_rst_count", 32'(pkt_count), 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
